// File: rtl/uart_echo_pkg.sv
// Shared constants for the UART echo engine: FSM encodings, transform modes
// and the byte case-transform helper.
package uart_echo_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [1:0] MODE_ECHO    = 2'd0;
  localparam logic [1:0] MODE_UPPER   = 2'd1;
  localparam logic [1:0] MODE_LOWER   = 2'd2;
  localparam logic [1:0] MODE_DISCARD = 2'd3;

  function automatic logic [7:0] echo_xform(input logic [7:0] b, input logic [1:0] mode);
    logic [7:0] r;
    r = b;
    if (mode == MODE_UPPER && b >= 8'h61 && b <= 8'h7A) begin
      r = b - 8'h20;
    end else if (mode == MODE_LOWER && b >= 8'h41 && b <= 8'h5A) begin
      r = b + 8'h20;
    end
    return r;
  endfunction

endpackage

// File: rtl/echo_byte_fifo.sv
// Small synchronous 8-bit FIFO; head is visible combinationally while non-empty.
// Push when full and pop when empty are ignored.
module echo_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra pointer bit tells full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (i_push && !o_full) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (i_pop && !o_empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_echo_engine.sv
// Wishbone master that pops bytes from the UART RX register, case-transforms them,
// buffers them and pushes them to the UART TX register; writes win over reads.
module uart_echo_engine
  import uart_echo_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int unsigned RX_ADDR     = 'h11,
  parameter int unsigned TX_ADDR     = 'h12,
  parameter int          BUF_DEPTH   = 4,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_rx_available,
  input  logic                  i_tx_full,
  input  logic [1:0]            i_mode,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [15:0]           o_rx_count,
  output logic [15:0]           o_tx_count
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]            state_q, state_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic [15:0]           rx_cnt_q, rx_cnt_d;
  logic [15:0]           tx_cnt_q, tx_cnt_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty, done;
  logic [7:0] fifo_head, push_byte;
  logic       unused_rd_bits;

  assign unused_rd_bits = ^i_wb_data[DATA_WIDTH-1:8];
  assign push_byte      = echo_xform(i_wb_data[7:0], i_mode);

  echo_byte_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (fifo_push),
    .i_data  (push_byte),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    stb_d     = stb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tmo_d     = '0;
    err_d     = 1'b0;
    rx_cnt_d  = rx_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !i_tx_full) begin
          state_d = ST_WRITE;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = ADDR_WIDTH'(TX_ADDR);
          data_d  = DATA_WIDTH'(fifo_head);
        end else if (i_rx_available && !fifo_full) begin
          state_d = ST_READ;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = ADDR_WIDTH'(RX_ADDR);
          data_d  = '0;
        end
      end
      ST_READ, ST_WRITE: begin
        if (i_wb_ack) begin
          done = 1'b1;
          if (state_q == ST_READ) begin
            rx_cnt_d  = rx_cnt_q + 16'd1;
            fifo_push = (i_mode != MODE_DISCARD);
          end else begin
            tx_cnt_d = tx_cnt_q + 16'd1;
            fifo_pop = 1'b1;
          end
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          // Abort leaves the buffer untouched so an unacked write is retried.
          done  = 1'b1;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: done = 1'b1;
    endcase
    if (done) begin
      state_d = ST_IDLE;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign o_wb_cyc   = stb_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = addr_q;
  assign o_wb_data  = data_q;
  assign o_err      = err_q;
  assign o_rx_count = rx_cnt_q;
  assign o_tx_count = tx_cnt_q;
  assign o_busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench: a UART-register slave model feeds RX bytes and acks cycles;
// acked writes are popped against an expected-byte queue filled at stimulus time.
module tb_uart_echo_engine;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [31:0] i_wb_data = '0;
  logic        i_wb_ack = 1'b0;
  logic        i_rx_available = 1'b0;
  logic        i_tx_full = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic        o_busy, o_err;
  logic [15:0] o_rx_count, o_tx_count;

  always #5 i_clk = ~i_clk;

  uart_echo_engine dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .o_wb_cyc       (o_wb_cyc),
    .o_wb_stb       (o_wb_stb),
    .o_wb_we        (o_wb_we),
    .o_wb_addr      (o_wb_addr),
    .o_wb_data      (o_wb_data),
    .i_wb_data      (i_wb_data),
    .i_wb_ack       (i_wb_ack),
    .i_rx_available (i_rx_available),
    .i_tx_full      (i_tx_full),
    .i_mode         (i_mode),
    .o_busy         (o_busy),
    .o_err          (o_err),
    .o_rx_count     (o_rx_count),
    .o_tx_count     (o_tx_count)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  bit          hold_ack = 1'b0;
  bit          expect_abort = 1'b0;
  bit          abort_seen = 1'b0;
  int          stb_run = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  logic        last_we = 1'b0;
  logic        rec_we = 1'b0;
  logic [31:0] rec_addr = '0;
  logic [31:0] rec_data = '0;
  logic [15:0] tmo_base_tx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Slave model and write monitor; acks on the second cycle of each strobe.
  always begin
    @(posedge i_clk);
    #1;
    if (o_err && !expect_abort) begin
      n_vec++;
      n_miss++;
      $display("FAIL unexpected_err: got 1, expected 0");
    end
    if (i_wb_ack) begin
      i_wb_ack = 1'b0;
      check("stb_low_after_ack", {31'b0, o_wb_stb}, 32'd0);
      if (rec_we) begin
        wr_seen++;
        check("wr_addr", rec_addr, 32'h12);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_write: got 'h%0h, expected no write", rec_data);
        end else begin
          check("wr_data", rec_data, {24'b0, exp_q.pop_front()});
        end
      end else begin
        rd_seen++;
        check("rd_addr", rec_addr, 32'h11);
        if (rx_q.size() != 0) void'(rx_q.pop_front());
      end
      stb_run = 0;
    end else if (!o_wb_stb && stb_run > 0) begin
      if (expect_abort) begin
        check("tmo_stb_cycles", stb_run, 15);
        check("tmo_err_pulse", {31'b0, o_err}, 32'd1);
        check("tmo_was_write", {31'b0, last_we}, 32'd1);
        check("tmo_tx_count_held", {16'b0, o_tx_count}, {16'b0, tmo_base_tx});
        hold_ack = 1'b0;
        expect_abort = 1'b0;
        abort_seen = 1'b1;
      end
      stb_run = 0;
    end
    if (o_wb_stb) begin
      stb_run++;
      last_we = o_wb_we;
      if (!hold_ack && stb_run >= 2) begin
        i_wb_ack = 1'b1;
        rec_we   = o_wb_we;
        rec_addr = o_wb_addr;
        rec_data = o_wb_data;
        if (!o_wb_we) i_wb_data = {24'hABCDEF, (rx_q.size() != 0) ? rx_q[0] : 8'h00};
      end
    end
    i_rx_available = (rx_q.size() != 0);
  end

  task automatic send(input logic [7:0] b, input logic [7:0] e, input bit wr);
    rx_q.push_back(b);
    if (wr) exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    for (int c = 0; c < 3000 && quiet < 4; c++) begin
      @(posedge i_clk);
      #1;
      if (rx_q.size() == 0 && !o_busy && !o_wb_stb) quiet++;
      else quiet = 0;
    end
    check(name, (quiet >= 4) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_counts(input string name, input int rx, input int tx);
    check({name, "_rx_count"}, {16'b0, o_rx_count}, rx);
    check({name, "_tx_count"}, {16'b0, o_tx_count}, tx);
  endtask

  logic [7:0] up_in[5]  = '{8'h61, 8'h5A, 8'h31, 8'h7A, 8'h7B};
  logic [7:0] up_out[5] = '{8'h41, 8'h5A, 8'h31, 8'h5A, 8'h7B};
  logic [7:0] lo_in[4]  = '{8'h48, 8'h40, 8'h5B, 8'h5A};
  logic [7:0] lo_out[4] = '{8'h68, 8'h40, 8'h5B, 8'h7A};

  initial begin
    int base_rd;
    int base_wr;
    int c;

    cycles(3);
    check("rst_stb", {31'b0, o_wb_stb}, 32'd0);
    check("rst_cyc", {31'b0, o_wb_cyc}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_err", {31'b0, o_err}, 32'd0);
    check_counts("rst", 0, 0);
    i_reset = 1'b0;
    cycles(2);

    i_mode = 2'd0;
    send(8'h41, 8'h41, 1'b1);
    wait_idle("echo_idle");
    check_counts("echo", 1, 1);

    i_mode = 2'd1;
    foreach (up_in[i]) send(up_in[i], up_out[i], 1'b1);
    wait_idle("upper_idle");
    check_counts("upper", 6, 6);

    i_mode = 2'd2;
    foreach (lo_in[i]) send(lo_in[i], lo_out[i], 1'b1);
    wait_idle("lower_idle");
    check_counts("lower", 10, 10);

    i_mode = 2'd3;
    send(8'h61, 8'h00, 1'b0);
    send(8'h62, 8'h00, 1'b0);
    send(8'h63, 8'h00, 1'b0);
    wait_idle("discard_idle");
    check_counts("discard", 13, 10);

    i_mode = 2'd0;
    i_tx_full = 1'b1;
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), 8'h10 + 8'(i), 1'b1);
    cycles(60);
    check_counts("bp_held", 17, 10);
    check("bp_busy", {31'b0, o_busy}, 32'd1);
    check("bp_stb_idle", {31'b0, o_wb_stb}, 32'd0);
    check("bp_rx_left", rx_q.size(), 2);
    base_rd = rd_seen;
    base_wr = wr_seen;
    i_tx_full = 1'b0;
    c = 0;
    while (c < 200 && wr_seen < base_wr + 4) begin
      cycles(1);
      c++;
    end
    check("bp_writes_first", wr_seen - base_wr, 4);
    check("bp_reads_after", rd_seen - base_rd, 0);
    wait_idle("bp_idle");
    check("bp_reads_total", rd_seen - base_rd, 2);
    check_counts("bp", 19, 16);

    i_tx_full = 1'b1;
    send(8'h5A, 8'h5A, 1'b1);
    cycles(15);
    tmo_base_tx  = o_tx_count;
    hold_ack     = 1'b1;
    expect_abort = 1'b1;
    abort_seen   = 1'b0;
    i_tx_full    = 1'b0;
    c = 0;
    while (c < 100 && !abort_seen) begin
      cycles(1);
      c++;
    end
    check("tmo_abort_seen", {31'b0, abort_seen}, 32'd1);
    hold_ack = 1'b0;
    expect_abort = 1'b0;
    cycles(1);
    check("tmo_err_one_cycle", {31'b0, o_err}, 32'd0);
    wait_idle("tmo_idle");
    check_counts("tmo_retry", 20, 17);

    hold_ack = 1'b1;
    send(8'h77, 8'h00, 1'b0);
    c = 0;
    while (c < 50 && !(o_wb_stb && !o_wb_we)) begin
      cycles(1);
      c++;
    end
    check("rstmid_read_started", {31'b0, o_wb_stb}, 32'd1);
    rx_q.delete();
    cycles(3);
    i_reset = 1'b1;
    cycles(1);
    i_reset = 1'b0;
    check("rstmid_stb", {31'b0, o_wb_stb}, 32'd0);
    check("rstmid_cyc", {31'b0, o_wb_cyc}, 32'd0);
    check("rstmid_busy", {31'b0, o_busy}, 32'd0);
    check_counts("rstmid", 0, 0);
    hold_ack = 1'b0;
    cycles(2);
    send(8'h42, 8'h42, 1'b1);
    wait_idle("post_rst_idle");
    check_counts("post_rst", 1, 1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
